// File: rtl/arith_issuer.sv
// Sequences one MoE token into the arithmetic pipeline: exp+sum pass, drain gap, normalise pass, then GeLU/aggregate beats.
// Latency: an accepted beat is issued on arith_* one cycle later; DIV replays start DRAIN_CYC idle cycles after the last exp issue.
// Backpressure: the pipeline never stalls; score_ready/act_ready depend only on state, and beats are held off rather than dropped.
module arith_issuer #(
    parameter int K_MAX     = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        score_valid,
    output logic        score_ready,
    input  logic [15:0] score_data,
    input  logic        score_last,
    input  logic        act_valid,
    output logic        act_ready,
    input  logic [15:0] act_data,
    input  logic [15:0] act_psum,
    input  logic        act_gelu,
    output logic        arith_valid,
    output logic [15:0] arith_data,
    output logic [15:0] arith_psum,
    output logic [1:0]  arith_mode,
    output logic        busy,
    output logic        err_overflow
);

    // Counter widths: KW holds 0..K_MAX, AW indexes the score buffer,
    // DW counts drain cycles 0..DRAIN_CYC-1.
    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;

    localparam logic [1:0] MODE_EXP  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_GELU = 2'd2;
    localparam logic [1:0] MODE_AGG  = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] wp_q, wp_d;
    logic [KW-1:0] rp_q, rp_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] agg_q, agg_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          err_q, err_d;
    logic          av_q, av_d;
    logic [15:0]   ad_q, ad_d;
    logic [15:0]   ap_q, ap_d;
    logic [1:0]    am_q, am_d;
    logic [15:0]   buf_q [K_MAX];
    logic [15:0]   buf_d [K_MAX];

    logic score_hs;
    logic act_hs;

    // Ready depends only on state so upstream never sees a valid->ready loop.
    always_comb begin
        score_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
        act_ready   = (state_q == S_STREAM);
        busy        = (state_q != S_IDLE);
        score_hs    = score_valid && score_ready;
        act_hs      = act_valid && act_ready;
    end

    // Next-state, buffer write and issue selection for all five phases.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        k_d     = k_q;
        agg_d   = agg_q;
        drain_d = drain_q;
        err_d   = err_q;
        buf_d   = buf_q;
        av_d    = 1'b0;
        ad_d    = ad_q;
        ap_d    = ap_q;
        am_d    = am_q;

        case (state_q)
            S_IDLE: begin
                if (score_hs) begin
                    buf_d[0] = score_data;
                    av_d     = 1'b1;
                    ad_d     = score_data;
                    ap_d     = 16'h0000;
                    am_d     = MODE_EXP;
                    wp_d     = KW'(1);
                    if (score_last) begin
                        k_d     = KW'(1);
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (score_hs) begin
                    buf_d[wp_q[AW-1:0]] = score_data;
                    av_d = 1'b1;
                    ad_d = score_data;
                    ap_d = 16'h0000;
                    am_d = MODE_EXP;
                    wp_d = wp_q + KW'(1);
                    // A full buffer closes the group; a missing last is flagged.
                    if (score_last || (wp_q == KW'(K_MAX - 1))) begin
                        k_d     = wp_q + KW'(1);
                        drain_d = '0;
                        state_d = S_DRAIN;
                        if (!score_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            S_DRAIN: begin
                // Gives the pipeline time to finish accumulating the exp sum.
                if (drain_q == DW'(DRAIN_CYC - 1)) begin
                    rp_d    = '0;
                    state_d = S_DIV;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end

            S_DIV: begin
                av_d = 1'b1;
                ad_d = buf_q[rp_q[AW-1:0]];
                ap_d = 16'h0000;
                am_d = MODE_DIV;
                rp_d = rp_q + KW'(1);
                if (rp_q == (k_q - KW'(1))) begin
                    agg_d   = '0;
                    state_d = S_STREAM;
                end
            end

            S_STREAM: begin
                if (act_hs) begin
                    av_d = 1'b1;
                    ad_d = act_data;
                    if (act_gelu) begin
                        ap_d = 16'h0000;
                        am_d = MODE_GELU;
                    end else begin
                        ap_d  = act_psum;
                        am_d  = MODE_AGG;
                        agg_d = agg_q + KW'(1);
                        // Only aggregate beats count towards closing the token.
                        if ((agg_q + KW'(1)) == k_q) begin
                            wp_d    = '0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset returns to IDLE with zeroed outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            k_q     <= '0;
            agg_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            av_q    <= 1'b0;
            ad_q    <= 16'h0000;
            ap_q    <= 16'h0000;
            am_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            k_q     <= k_d;
            agg_q   <= agg_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            av_q    <= av_d;
            ad_q    <= ad_d;
            ap_q    <= ap_d;
            am_q    <= am_d;
        end
    end

    // Score storage carries no reset: stale entries are never read before rewrite.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign arith_valid  = av_q;
    assign arith_data   = ad_q;
    assign arith_psum   = ap_q;
    assign arith_mode   = am_q;
    assign err_overflow = err_q;

endmodule
